fir_y_sched: RTL

- Sequencer for the vertical polyphase decimation MAC, which has a 5-row tap window and supports decimation factor 1..5.
- Counts input lines landing in a circular line buffer. Once a full group of `dec` lines is present, it sweeps the columns, issuing line-buffer reads plus a one-cycle-delayed MAC load strobe per column.
- Advances the ring base by `dec` after each output row.
- Holds the coefficient set stable for the frame and signals frame completion after the MAC pipeline drains.

---
 rtl/fir_y_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fir_y_sched.sv
// Vertical polyphase decimation sequencer: tracks lines landing in a circular
// line buffer and sweeps one column pass per output row once `dec` lines are present.
module fir_y_sched #(
  parameter int AW       = 10,
  parameter int LB_LINES = 10,
  parameter int HW       = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [2:0]    cfg_dec,
  input  logic [AW-1:0] cfg_width,
  input  logic [HW-1:0] cfg_height,
  input  logic          line_in_done,
  output logic [3:0]    lb_base,
  output logic          lb_rd_en,
  output logic [AW-1:0] lb_rd_addr,
  output logic          en_load,
  output logic [2:0]    coef_set,
  output logic          lb_full,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err,
  output logic          ovf_err
);
  localparam int         DRAIN_CYC = 3;
  localparam int         UW        = HW + 1;
  localparam logic [4:0] LB_N      = 5'(LB_LINES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state_q, state_d;

  logic [2:0]    dec_q;
  logic [AW-1:0] width_q;
  logic [HW-1:0] height_q;
  logic [AW-1:0] col_q;
  logic [4:0]    avail_q, avail_d;
  logic [UW-1:0] used_q, used_nxt, dec_x;
  logic [3:0]    base_q;
  logic [4:0]    base_sum, base_wrap;
  logic          base_adv_q;
  logic [1:0]    drain_q;
  logic          en_load_q, cfg_err_q, ovf_q;
  logic          cfg_ok, accept, reject, active, full, inc, drop, row_end, last_row;

  always_comb begin
    cfg_ok   = (cfg_dec inside {[3'd1:3'd5]}) && (cfg_width != '0) &&
               (cfg_height >= HW'(cfg_dec));
    accept   = (state_q == S_IDLE) && cfg_start && cfg_ok;
    reject   = (state_q == S_IDLE) && cfg_start && !cfg_ok;
    active   = (state_q != S_IDLE);
    full     = (avail_q == LB_N);
    inc      = active && line_in_done && !full;
    drop     = active && line_in_done && full;
    row_end  = (state_q == S_READ) && (col_q == width_q - AW'(1));
    dec_x    = UW'(dec_q);
    used_nxt = used_q + dec_x;
    // Another row needs a full group of fresh lines; leftovers below dec are dropped.
    last_row = (used_nxt + dec_x) > UW'(height_q);
    avail_d  = avail_q + 5'(inc) - (row_end ? 5'(dec_q) : 5'd0);
    // base < LB_LINES and dec <= 5 < LB_LINES, so one conditional subtract wraps.
    base_sum  = 5'(base_q) + 5'(dec_q);
    base_wrap = (base_sum >= LB_N) ? base_sum - LB_N : base_sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (avail_q >= 5'(dec_q)) state_d = S_READ;
      S_READ:  if (row_end) state_d = last_row ? S_DRAIN : S_WAIT;
      S_DRAIN: if (drain_q == 2'(DRAIN_CYC - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      en_load_q <= 1'b0;
      cfg_err_q <= 1'b0;
      drain_q   <= '0;
      col_q     <= '0;
    end else begin
      state_q   <= state_d;
      en_load_q <= (state_q == S_READ);
      cfg_err_q <= reject;
      drain_q   <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;
      col_q     <= (state_q == S_READ && !row_end) ? col_q + AW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
    end else if (accept) begin
      dec_q    <= cfg_dec;
      width_q  <= cfg_width;
      height_q <= cfg_height;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q    <= '0;
      used_q     <= '0;
      base_q     <= '0;
      base_adv_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      avail_q    <= active ? avail_d : 5'd0;
      // Base moves one cycle after the last read so the trailing load still sees the old base.
      base_adv_q <= row_end;
      if (accept)        used_q <= '0;
      else if (row_end)  used_q <= used_nxt;
      if (accept)          base_q <= '0;
      else if (base_adv_q) base_q <= base_wrap[3:0];
      if (accept)    ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  assign lb_base    = base_q;
  assign lb_rd_en   = (state_q == S_READ);
  assign lb_rd_addr = col_q;
  assign en_load    = en_load_q;
  assign coef_set   = dec_q;
  assign lb_full    = full;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign cfg_err    = cfg_err_q;
  assign ovf_err    = ovf_q;

  a_avail_max: assert property (@(posedge clk) disable iff (!rst_n) avail_q <= LB_N);
  a_base_rng:  assert property (@(posedge clk) disable iff (!rst_n) 5'(base_q) < LB_N);

endmodule
